gpio_stim_tx: RTL

Transmitter side of the two-board sensor link. It drives the 2-bit A and B photoresistor-emulation lines, the manual clock pulse and the manual reset pulse onto GPIO for the receiving board. It then samples that board's decoupling output back through a synchronizer. Lets a second FPGA run the receiver automatically instead of through light sensors and push-buttons; runs on CLOCK_50 at the sending end.

---
 rtl/gpio_stim_tx_pkg.sv | 12 +
 rtl/gpio_stim_tx_if.sv | 13 +
 rtl/gpio_stim_tx_sync2.sv | 18 +
 rtl/gpio_stim_tx.sv | 91 +++++++++
 4 files changed

// File: rtl/gpio_stim_tx_pkg.sv
// gpio_stim_pkg: shared states, op codes and counter sizing for the GPIO stimulus transmitter
package gpio_stim_pkg;
  typedef enum logic [2:0] {IDLE, SETUP, PULSE, HOLD, SETTLE, RSTP} state_t;
  localparam logic OP_SEND = 1'b0;
  localparam logic OP_RESET = 1'b1;
  function automatic int max2(input int x, input int y);
    return x > y ? x : y;
  endfunction
  function automatic int cnt_width(input int m);
    return m > 1 ? $clog2(m) : 1;
  endfunction
endpackage

// File: rtl/gpio_stim_tx_if.sv
// gpio_stim_tx_if: command/response handshake between a command source and the transmitter
interface gpio_stim_tx_if;
  logic cmd_valid;
  logic cmd_ready;
  logic cmd_op;
  logic [1:0] cmd_a;
  logic [1:0] cmd_b;
  logic resp_valid;
  logic resp_op;
  logic fb_data;
  modport master (output cmd_valid, cmd_op, cmd_a, cmd_b, input cmd_ready, resp_valid, resp_op, fb_data);
  modport slave (input cmd_valid, cmd_op, cmd_a, cmd_b, output cmd_ready, resp_valid, resp_op, fb_data);
endinterface

// File: rtl/gpio_stim_tx_sync2.sv
// sync2: two-flop synchronizer for a single asynchronous input
module sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic q1;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q1 <= 1'b0;
      q <= 1'b0;
    end else begin
      q1 <= d;
      q <= q1;
    end
  end
endmodule

// File: rtl/gpio_stim_tx.sv
// gpio_stim_tx: sequences A/B data, clock and reset pulses onto GPIO and samples the receiver's feedback
module gpio_stim_tx
  import gpio_stim_pkg::*;
#(
  parameter int SETUP_CYCLES = 50,
  parameter int PULSE_CYCLES = 500,
  parameter int HOLD_CYCLES = 50,
  parameter int SETTLE_CYCLES = 1000,
  parameter int RST_CYCLES = 500
) (
  input  logic clk,
  input  logic rst,
  gpio_stim_tx_if.slave bus,
  output logic [1:0] a_out,
  output logic [1:0] b_out,
  output logic clk_pulse_out,
  output logic rst_pulse_out,
  input  logic fb_in
);
  localparam int MAXP = max2(max2(max2(SETUP_CYCLES, PULSE_CYCLES), max2(HOLD_CYCLES, SETTLE_CYCLES)), RST_CYCLES);
  localparam int CW = cnt_width(MAXP);
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic op, done, sync_fb, last;
  sync2 u_sync (.clk(clk), .rst(rst), .d(fb_in), .q(sync_fb));
  assign bus.cmd_ready = state == IDLE && !rst;
  assign last = cnt == '0;
  always_comb begin
    state_n = state;
    cnt_n = cnt - 1'b1;
    done = 1'b0;
    case (state)
      IDLE: if (bus.cmd_valid) begin
        state_n = bus.cmd_op == OP_RESET ? RSTP : SETUP;
        cnt_n = bus.cmd_op == OP_RESET ? CW'(RST_CYCLES - 1) : CW'(SETUP_CYCLES - 1);
      end
      SETUP: if (last) begin
        state_n = PULSE;
        cnt_n = CW'(PULSE_CYCLES - 1);
      end
      PULSE: if (last) begin
        state_n = HOLD;
        cnt_n = CW'(HOLD_CYCLES - 1);
      end
      HOLD: if (last) begin
        state_n = op == OP_RESET ? IDLE : SETTLE;
        cnt_n = CW'(SETTLE_CYCLES - 1);
        done = op == OP_RESET;
      end
      SETTLE: if (last) begin
        state_n = IDLE;
        done = 1'b1;
      end
      RSTP: if (last) begin
        state_n = HOLD;
        cnt_n = CW'(HOLD_CYCLES - 1);
      end
      default: state_n = IDLE;
    endcase
  end
  // pulse outputs are registered from the next state so the GPIO pins never glitch
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      op <= OP_SEND;
      a_out <= '0;
      b_out <= '0;
      clk_pulse_out <= 1'b0;
      rst_pulse_out <= 1'b0;
      bus.resp_valid <= 1'b0;
      bus.resp_op <= 1'b0;
      bus.fb_data <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      if (state == IDLE && bus.cmd_valid) begin
        op <= bus.cmd_op;
        if (bus.cmd_op == OP_SEND) begin
          a_out <= bus.cmd_a;
          b_out <= bus.cmd_b;
        end
      end
      clk_pulse_out <= state_n == PULSE;
      rst_pulse_out <= state_n == RSTP;
      bus.resp_valid <= done;
      if (done) bus.resp_op <= op;
      if (state == SETTLE && last) bus.fb_data <= sync_fb;
    end
  end
endmodule
